// File: rtl/clm_column_feeder_if.sv
// Handshake bundle between the CLM column feeder and its neighbours:
// the state input, the randomness input and the column output toward the mixer.
interface clm_column_feeder_if #(
  parameter int D = 1
);
  localparam int StateW = 8 * (D + 1);
  localparam int RndW   = 8 * (D + 1);

  logic                        in_valid;
  logic                        in_ready;
  logic [0:15][StateW-1:0]     in_state;

  logic                        rnd_valid;
  logic                        rnd_ready;
  logic [0:15][RndW-1:0]       rnd_in;

  logic                        out_valid;
  logic                        out_ready;
  logic [0:3][StateW-1:0]      out_col;
  logic [0:15][RndW-1:0]       out_rnd;
  logic [1:0]                  out_idx;
  logic                        out_last;

  // master is the environment around the feeder; slave is the feeder itself
  modport master (
    output in_valid, in_state, rnd_valid, rnd_in, out_ready,
    input  in_ready, rnd_ready, out_valid, out_col, out_rnd, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_state, rnd_valid, rnd_in, out_ready,
    output in_ready, rnd_ready, out_valid, out_col, out_rnd, out_idx, out_last
  );
endinterface

// File: rtl/clm_column_feeder.sv
// Upstream stage of the CLM MixColumns datapath: buffers one masked state, applies
// ShiftRows by index selection and emits one column per fire with its own random vector.
module clm_column_feeder #(
  parameter int D = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  clm_column_feeder_if.slave   feed_io
);
  localparam int StateW = 8 * (D + 1);
  localparam int RndW   = 8 * (D + 1);

  typedef logic [StateW-1:0]   state_t;
  typedef logic [RndW-1:0]     red_poly_t;
  typedef state_t [0:3]        state_word_t;

  typedef enum logic [0:0] {
    IDLE,
    SEND
  } feed_state_e;

  feed_state_e          fsm_q, fsm_d;
  logic [1:0]           cnt_q, cnt_d;
  state_t [0:15]        stateBuf_q, stateBuf_d;
  red_poly_t [0:15]     rndBuf_q, rndBuf_d;
  logic                 rndFull_q, rndFull_d;

  logic                 inReady;
  logic                 rndReady;
  logic                 outValid;
  logic                 inFire;
  logic                 rndFire;
  logic                 outFire;
  state_word_t          outCol;

  // Ready signals are forced low while reset is held so nothing is accepted mid-reset
  always_comb begin
    outValid = rst_n && (fsm_q == SEND) && rndFull_q;
    outFire  = outValid && feed_io.out_ready;
    inReady  = rst_n && (fsm_q == IDLE);
    inFire   = inReady && feed_io.in_valid;
    rndReady = rst_n && (!rndFull_q || outFire);
    rndFire  = rndReady && feed_io.rnd_valid;
  end

  always_comb begin
    fsm_d      = fsm_q;
    cnt_d      = cnt_q;
    stateBuf_d = stateBuf_q;
    unique case (fsm_q)
      IDLE: begin
        if (inFire) begin
          stateBuf_d = feed_io.in_state;
          cnt_d      = 2'd0;
          fsm_d      = SEND;
        end
      end
      SEND: begin
        if (outFire) begin
          if (cnt_q == 2'd3) begin
            cnt_d = 2'd0;
            fsm_d = IDLE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: begin
        fsm_d = IDLE;
        cnt_d = 2'd0;
      end
    endcase
  end

  // A new vector may land in the same cycle the held one is consumed, so fill wins over drain
  always_comb begin
    rndBuf_d  = rndBuf_q;
    rndFull_d = rndFull_q;
    if (rndFire) begin
      rndBuf_d  = feed_io.rnd_in;
      rndFull_d = 1'b1;
    end else if (outFire) begin
      rndFull_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q      <= IDLE;
      cnt_q      <= 2'd0;
      stateBuf_q <= '0;
      rndBuf_q   <= '0;
      rndFull_q  <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      cnt_q      <= cnt_d;
      stateBuf_q <= stateBuf_d;
      rndBuf_q   <= rndBuf_d;
      rndFull_q  <= rndFull_d;
    end
  end

  // ShiftRows: row r of output column c comes from column (c + r) mod 4, element = 4*col + row
  for (genvar r = 0; r < 4; r++) begin : g_row
    logic [1:0] colSel;
    assign colSel    = cnt_q + 2'(r);
    assign outCol[r] = stateBuf_q[{colSel, 2'(r)}];
  end

  assign feed_io.in_ready  = inReady;
  assign feed_io.rnd_ready = rndReady;
  assign feed_io.out_valid = outValid;
  assign feed_io.out_col   = outCol;
  assign feed_io.out_rnd   = rndBuf_q;
  assign feed_io.out_idx   = cnt_q;
  assign feed_io.out_last  = (cnt_q == 2'd3);
endmodule

// File: tb/tb_clm_column_feeder.sv
// Directed, table-driven bench for clm_column_feeder: per-cycle stimulus rows with
// hand-computed ShiftRows columns and randomness ids, plus a hand-written stall/latency sequence.
module tb_clm_column_feeder;
  localparam int D = 1;
  localparam int W = 8 * (D + 1);

  typedef logic [0:15][W-1:0] vec16_t;

  // One cycle: stimulus, then expected outputs; chk enables column/randomness checks
  typedef struct {
    int rst;  int iv;  int base; int rv;  int rid; int ordy;
    int eov;  int eir; int err;  int eidx; int elast;
    int chk;  int c0;  int c1;   int c2;   int c3;  int erid;
  } vec_t;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  clm_column_feeder_if #(.D(D)) feedIf();

  clm_column_feeder #(.D(D)) dut (
    .clk     (clk),
    .rst_n   (rstN),
    .feed_io (feedIf.slave)
  );

  int nVec = 0;
  int nCmp = 0;
  int nErr = 0;
  vec_t tbl[$];

  function automatic vec16_t mkState(int base);
    vec16_t v;
    for (int k = 0; k < 16; k++) v[k] = W'(base + k);
    return v;
  endfunction

  // Word j of vector id is id*(17+j): id 0 is all-zero, every other id is distinct
  function automatic vec16_t mkRnd(int id);
    vec16_t v;
    for (int j = 0; j < 16; j++) v[j] = W'(id * (17 + j));
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCmp++;
    if (actual !== expected) begin
      nErr++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkVec(input string name, input vec16_t actual, input vec16_t expected);
    nCmp++;
    if (actual !== expected) begin
      nErr++;
      $display("[TB] FAIL %s: got word0=%0d word15=%0d, expected word0=%0d word15=%0d",
               name, actual[0], actual[15], expected[0], expected[15]);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rstN             = v.rst[0];
    feedIf.in_valid  = v.iv[0];
    feedIf.in_state  = mkState(v.base);
    feedIf.rnd_valid = v.rv[0];
    feedIf.rnd_in    = mkRnd(v.rid);
    feedIf.out_ready = v.ordy[0];
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int waited;
    rstN             = 1'b0;
    feedIf.in_valid  = 1'b0;
    feedIf.in_state  = '0;
    feedIf.rnd_valid = 1'b0;
    feedIf.rnd_in    = '0;
    feedIf.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    nVec++;
    checkOutput("rst out_valid", feedIf.out_valid, 0);
    checkOutput("rst in_ready", feedIf.in_ready, 0);
    checkOutput("rst rnd_ready", feedIf.rnd_ready, 0);
    checkOutput("rst out_idx", feedIf.out_idx, 0);
    checkOutput("rst out_last", feedIf.out_last, 0);
    checkOutput("rst out_col", feedIf.out_col, 0);
    checkVec("rst out_rnd", feedIf.out_rnd, '0);

    // basic state k=k, distinct vectors, out_ready=1; ends with a prefetched vector in IDLE
    tbl.push_back('{1,1,0,1,1,1,    0,1,1,0,0, 0,0,0,0,0,0});
    tbl.push_back('{1,0,0,1,2,1,    1,0,1,0,0, 1,0,5,10,15,1});
    tbl.push_back('{1,0,0,1,3,1,    1,0,1,1,0, 1,4,9,14,3,2});
    tbl.push_back('{1,0,0,1,4,1,    1,0,1,2,0, 1,8,13,2,7,3});
    tbl.push_back('{1,0,0,1,5,1,    1,0,1,3,1, 1,12,1,6,11,4});
    tbl.push_back('{1,0,0,1,6,1,    0,1,0,0,0, 0,0,0,0,0,0});
    // out_ready held low three cycles on column 1
    tbl.push_back('{1,1,16,1,6,1,   0,1,0,0,0, 0,0,0,0,0,0});
    tbl.push_back('{1,0,16,1,6,1,   1,0,1,0,0, 1,16,21,26,31,5});
    tbl.push_back('{1,0,16,1,7,0,   1,0,0,1,0, 1,20,25,30,19,6});
    tbl.push_back('{1,0,16,1,7,0,   1,0,0,1,0, 1,20,25,30,19,6});
    tbl.push_back('{1,0,16,1,7,0,   1,0,0,1,0, 1,20,25,30,19,6});
    tbl.push_back('{1,0,16,1,7,1,   1,0,1,1,0, 1,20,25,30,19,6});
    tbl.push_back('{1,0,16,1,8,1,   1,0,1,2,0, 1,24,29,18,23,7});
    tbl.push_back('{1,0,16,1,9,1,   1,0,1,3,1, 1,28,17,22,27,8});
    // randomness withheld after the prefetched vector
    tbl.push_back('{1,1,32,0,0,1,   0,1,0,0,0, 0,0,0,0,0,0});
    tbl.push_back('{1,0,32,0,0,1,   1,0,1,0,0, 1,32,37,42,47,9});
    tbl.push_back('{1,0,32,0,0,1,   0,0,1,1,0, 0,0,0,0,0,0});
    tbl.push_back('{1,0,32,0,0,1,   0,0,1,1,0, 0,0,0,0,0,0});
    tbl.push_back('{1,0,32,1,10,1,  0,0,1,1,0, 0,0,0,0,0,0});
    tbl.push_back('{1,0,32,1,11,1,  1,0,1,1,0, 1,36,41,46,35,10});
    tbl.push_back('{1,0,32,1,12,1,  1,0,1,2,0, 1,40,45,34,39,11});
    tbl.push_back('{1,0,32,1,13,1,  1,0,1,3,1, 1,44,33,38,43,12});
    // second state offered during SEND is ignored until IDLE
    tbl.push_back('{1,1,48,1,14,1,  0,1,0,0,0, 0,0,0,0,0,0});
    tbl.push_back('{1,1,64,1,14,1,  1,0,1,0,0, 1,48,53,58,63,13});
    tbl.push_back('{1,1,64,1,15,1,  1,0,1,1,0, 1,52,57,62,51,14});
    tbl.push_back('{1,1,64,1,16,1,  1,0,1,2,0, 1,56,61,50,55,15});
    tbl.push_back('{1,1,64,1,17,1,  1,0,1,3,1, 1,60,49,54,59,16});
    tbl.push_back('{1,1,64,1,18,1,  0,1,0,0,0, 0,0,0,0,0,0});
    tbl.push_back('{1,0,64,1,18,1,  1,0,1,0,0, 1,64,69,74,79,17});
    tbl.push_back('{1,0,64,1,19,1,  1,0,1,1,0, 1,68,73,78,67,18});
    // reset after column 1 fires, then a fresh state from index 0
    tbl.push_back('{0,1,80,1,20,1,  0,0,0,2,0, 0,0,0,0,0,0});
    tbl.push_back('{1,0,80,0,0,1,   0,1,1,0,0, 1,0,0,0,0,0});
    tbl.push_back('{1,1,80,1,20,1,  0,1,1,0,0, 0,0,0,0,0,0});
    tbl.push_back('{1,0,80,1,21,1,  1,0,1,0,0, 1,80,85,90,95,20});
    tbl.push_back('{1,1,96,1,22,1,  1,0,1,1,0, 1,84,89,94,83,21});
    tbl.push_back('{1,1,96,1,23,1,  1,0,1,2,0, 1,88,93,82,87,22});
    tbl.push_back('{1,1,96,1,24,1,  1,0,1,3,1, 1,92,81,86,91,23});
    // back-to-back states: 8 columns in 10 cycles
    tbl.push_back('{1,1,96,1,25,1,  0,1,0,0,0, 0,0,0,0,0,0});
    tbl.push_back('{1,1,112,1,25,1, 1,0,1,0,0, 1,96,101,106,111,24});
    tbl.push_back('{1,1,112,1,26,1, 1,0,1,1,0, 1,100,105,110,99,25});
    tbl.push_back('{1,1,112,1,27,1, 1,0,1,2,0, 1,104,109,98,103,26});
    tbl.push_back('{1,1,112,1,28,1, 1,0,1,3,1, 1,108,97,102,107,27});
    tbl.push_back('{1,1,112,1,29,1, 0,1,0,0,0, 0,0,0,0,0,0});
    tbl.push_back('{1,0,112,1,29,1, 1,0,1,0,0, 1,112,117,122,127,28});
    tbl.push_back('{1,0,112,1,30,1, 1,0,1,1,0, 1,116,121,126,115,29});
    tbl.push_back('{1,0,112,1,31,1, 1,0,1,2,0, 1,120,125,114,119,30});
    tbl.push_back('{1,0,112,1,32,1, 1,0,1,3,1, 1,124,113,118,123,31});
    tbl.push_back('{1,0,112,0,0,1,  0,1,0,0,0, 0,0,0,0,0,0});

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      applyStimulus(tbl[i]);
      nVec++;
      checkOutput($sformatf("row%0d out_valid", i), feedIf.out_valid, tbl[i].eov);
      checkOutput($sformatf("row%0d in_ready", i), feedIf.in_ready, tbl[i].eir);
      checkOutput($sformatf("row%0d rnd_ready", i), feedIf.rnd_ready, tbl[i].err);
      checkOutput($sformatf("row%0d out_idx", i), feedIf.out_idx, tbl[i].eidx);
      checkOutput($sformatf("row%0d out_last", i), feedIf.out_last, tbl[i].elast);
      if (tbl[i].chk != 0) begin
        checkOutput($sformatf("row%0d col[0]", i), feedIf.out_col[0], tbl[i].c0);
        checkOutput($sformatf("row%0d col[1]", i), feedIf.out_col[1], tbl[i].c1);
        checkOutput($sformatf("row%0d col[2]", i), feedIf.out_col[2], tbl[i].c2);
        checkOutput($sformatf("row%0d col[3]", i), feedIf.out_col[3], tbl[i].c3);
        checkVec($sformatf("row%0d out_rnd", i), feedIf.out_rnd, mkRnd(tbl[i].erid));
      end
    end

    // Hand sequence: state arrives with no randomness available, output must stall
    @(negedge clk);
    rstN = 1'b0;
    #1;
    nVec++;
    checkOutput("seq rst in_ready", feedIf.in_ready, 0);
    @(negedge clk);
    rstN             = 1'b1;
    feedIf.in_valid  = 1'b1;
    feedIf.in_state  = mkState(128);
    feedIf.rnd_valid = 1'b0;
    feedIf.out_ready = 1'b0;
    #1;
    nVec++;
    checkOutput("seq in_ready", feedIf.in_ready, 1);
    checkOutput("seq rnd_ready empty", feedIf.rnd_ready, 1);
    @(negedge clk);
    feedIf.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      nVec++;
      checkOutput($sformatf("seq stall%0d out_valid", c), feedIf.out_valid, 0);
      checkOutput($sformatf("seq stall%0d in_ready", c), feedIf.in_ready, 0);
      @(negedge clk);
    end
    feedIf.rnd_valid = 1'b1;
    feedIf.rnd_in    = mkRnd(40);
    #1;
    nVec++;
    checkOutput("seq rnd_ready", feedIf.rnd_ready, 1);
    waited = 0;
    do begin
      @(negedge clk);
      #1;
      waited++;
    end while (feedIf.out_valid !== 1'b1 && waited < 5);
    nVec++;
    checkOutput("seq rnd-to-valid cycles", waited, 1);
    checkOutput("seq out_idx", feedIf.out_idx, 0);
    checkOutput("seq col[0]", feedIf.out_col[0], 128);
    checkOutput("seq col[1]", feedIf.out_col[1], 133);
    checkOutput("seq col[2]", feedIf.out_col[2], 138);
    checkOutput("seq col[3]", feedIf.out_col[3], 143);
    checkVec("seq out_rnd", feedIf.out_rnd, mkRnd(40));
    checkOutput("seq rnd_ready full", feedIf.rnd_ready, 0);
    feedIf.rnd_valid = 1'b0;
    feedIf.out_ready = 1'b1;
    #1;
    checkOutput("seq rnd_ready on fire", feedIf.rnd_ready, 1);
    @(negedge clk);
    #1;
    nVec++;
    checkOutput("seq drained out_valid", feedIf.out_valid, 0);
    checkOutput("seq drained out_idx", feedIf.out_idx, 1);
    checkOutput("seq drained rnd_ready", feedIf.rnd_ready, 1);

    $display("[TB] %0d comparisons made", nCmp);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule

// File: doc/clm_column_feeder.md
Name: clm_column_feeder

Overview:
- Upstream stage of the CLM single-column MixColumns datapath.
- Accepts one full masked 16-element state per handshake and applies ShiftRows by index selection.
- Emits one column per cycle to the column mixer, each paired with a fresh 16-word red_poly_t random vector.
- No randomness word is ever issued to more than one column.

Parameters:
- d, d (codebase-wide value), CLM masking order; fixes the widths of state_t, state_word_t and red_poly_t.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  in_state is valid
- in_ready  out  1  block can accept a state
- in_state  in  16 x state_t  masked state, element k = row (k mod 4), column (k div 4)
- rnd_valid  in  1  rnd_in is valid
- rnd_ready  out  1  block can accept a random vector
- rnd_in  in  red_poly_t[0:15]  fresh randomness for one column
- out_valid  out  1  out_col and out_rnd are valid
- out_ready  in  1  downstream accepts
- out_col  out  state_word_t  shifted column, element r = row r
- out_rnd  out  red_poly_t[0:15]  random vector bound to out_col
- out_idx  out  2  column index 0..3
- out_last  out  1  high when out_idx==3

Behaviour:
- Clocking and reset
  - Single clock; all state updates on the rising edge of clk.
  - Reset is synchronous and active-low: rst_n=0 sampled at a rising edge resets the block.
  - Reset values: FSM=IDLE, col counter=0, rnd_full=0, state buffer=0, rnd buffer=0.
  - Reset output values: in_ready=0 while rst_n=0, 1 after; rnd_ready=0 while rst_n=0, 1 after; out_valid=0, out_idx=0, out_last=0, out_col=0, out_rnd=0.
  - Reset mid-operation discards the buffered state and randomness; no partial column is emitted afterwards.
- FSM
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_state, set counter=0, go to SEND.
  - SEND: in_ready=0. On the out fire (out_valid&out_ready) with counter==3, return to IDLE. Otherwise the out fire increments counter.
- Output mapping
  - out_col[r] = buffer element at row r, column ((out_idx+r) mod 4).
  - The mapping is combinational from the registered buffer and counter.
  - out_idx = counter; out_last = (counter==3).
- Randomness buffer
  - One-entry buffer with flag rnd_full.
  - rnd_ready = !rnd_full | out fire; accepting a new vector in the same cycle as a fire is allowed.
  - rnd fire (rnd_valid&rnd_ready) loads rnd_in and sets rnd_full.
  - An out fire without a simultaneous rnd fire clears rnd_full.
  - out_rnd = rnd buffer.
  - Randomness may be prefetched in IDLE.
- Handshake rules
  - out_valid = (FSM==SEND) & rnd_full.
  - While out_valid=1 and out_ready=0, out_col, out_rnd, out_idx and out_last hold stable.
  - out_valid never drops without a fire, except on reset.
- Latency and throughput
  - Input fire at cycle N gives out_valid at N+1 when rnd_full.
  - Throughput is 4 columns per 5 cycles back-to-back (one IDLE cycle between states).
- Boundary conditions
  - in_valid during SEND is ignored and in_state is not sampled.
  - rnd_valid=0 stalls output; no column is ever issued with stale or reused randomness.
  - Counter wraps only via the return to IDLE.

Test Plan:
- Reset, then in_state element k = k (values 0..15), rnd always valid with distinct vectors, out_ready=1 -> columns {0,5,10,15}, {4,9,14,3}, {8,13,2,7}, {12,1,6,11}; out_idx 0..3; out_last only on the 4th; each out_rnd is a distinct vector.
- Hold out_ready=0 for 3 cycles on column 1 -> outputs stable; rnd_ready=0; no vector consumed; resumes with column 2 and the next vector.
- rnd_valid=0 after the first vector -> column 0 issued; out_valid=0 until rnd_valid=1; column 1 then uses the new vector.
- Assert in_valid with a second state during SEND -> ignored, in_ready=0; second state accepted one cycle after column 3 fires.
- rst_n=0 after column 1 fires -> next cycle out_valid=0, in_ready=0, rnd_ready=0; after release, a new state starts at out_idx=0.
- Back-to-back states with out_ready=1 and rnd always valid -> 8 columns in 10 cycles; rnd fire coincides with each out fire and no vector is repeated.
